// File: rtl/data_memory_ws.sv
// Byte-addressed, little-endian data memory with req/ready/valid handshake and a
// programmable access latency; supports sub-word loads/stores with extension.
module data_memory_ws #(
    parameter int    DATA_W      = 32,
    parameter int    ADDR_W      = 13,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = "DataMemory.txt"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign_err
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // Handshake: a request transfers on a rising edge where req=1 and ready=1;
    // valid is a one-cycle completion pulse carrying rdata and misalign_err.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_uns;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic legal_in;
    logic latch, done_go, err_n, a_go;

    logic              a_we;
    logic [1:0]        a_size;
    logic              a_uns;
    logic [31:0]       a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [LB-1:0]     a_off;
    logic [ADDR_W-1:0] a_idx;

    logic [NB-1:0]     byte_en;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] ld_ext;
    logic              sign_bit;
    int                nbytes;
    int                nbits;

    logic unused_addr_bits;
    assign unused_addr_bits = ^a_addr[31:ADDR_W+LB];

    // Oversized accesses and addresses not a multiple of the access size are rejected.
    logic [3:0] align_mask;
    always_comb begin
        align_mask = 4'((1 << size) - 1);
        legal_in   = 1'b1;
        if (int'(size) > LB) legal_in = 1'b0;
        if ((addr[3:0] & align_mask) != 4'd0) legal_in = 1'b0;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        done_go = 1'b0;
        err_n   = 1'b0;
        a_go    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (req && ready) begin
                    latch = 1'b1;
                    if (!legal_in) begin
                        state_n = S_DONE;
                        done_go = 1'b1;
                        err_n   = 1'b1;
                    end else if (NO_WAIT) begin
                        state_n = S_DONE;
                        done_go = 1'b1;
                        a_go    = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = S_DONE;
                    done_go = 1'b1;
                    a_go    = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Zero-wait accesses use the live inputs at the accept edge; delayed ones use the latch.
    always_comb begin
        if (state == S_WAIT) begin
            a_we    = lat_we;
            a_size  = lat_size;
            a_uns   = lat_uns;
            a_addr  = lat_addr;
            a_wdata = lat_wdata;
        end else begin
            a_we    = we;
            a_size  = size;
            a_uns   = unsigned_ld;
            a_addr  = addr;
            a_wdata = wdata;
        end
        a_off = a_addr[LB-1:0];
        a_idx = a_addr[ADDR_W+LB-1:LB];
    end

    always_comb begin
        nbytes   = 1 << a_size;
        nbits    = 8 << a_size;
        byte_en  = '0;
        for (int b = 0; b < NB; b++) begin
            byte_en[b] = (b >= int'(a_off)) && (b < int'(a_off) + nbytes);
        end
        wdata_sh = a_wdata << {a_off, 3'b000};
        rd_raw   = mem[a_idx] >> {a_off, 3'b000};
        case (a_size)
            2'd0:    sign_bit = rd_raw[7];
            2'd1:    sign_bit = rd_raw[15];
            2'd2:    sign_bit = rd_raw[31];
            default: sign_bit = rd_raw[DATA_W-1];
        endcase
        ld_ext = rd_raw;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits) ld_ext[i] = a_uns ? 1'b0 : sign_bit;
        end
    end

    // Storage is never reset so committed writes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (a_go && a_we) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) mem[a_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            ready        <= 1'b0;
            valid        <= 1'b0;
            misalign_err <= 1'b0;
            rdata        <= '0;
            lat_we       <= 1'b0;
            lat_size     <= 2'd0;
            lat_uns      <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= (state_n != S_WAIT);
            valid <= done_go;
            if (done_go) misalign_err <= err_n;
            if (a_go && !a_we) rdata <= ld_ext;
            if (latch) begin
                lat_we    <= we;
                lat_size  <= size;
                lat_uns   <= unsigned_ld;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboarded bench for data_memory_ws: directed requests push expected
// completions; a negedge monitor pops and compares rdata, error flag and timing.
module tb_data_memory_ws;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    logic        misalign_err;

    data_memory_ws #(
        .DATA_W(32),
        .ADDR_W(13),
        .WAIT_CYCLES(W),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .we(we),
        .size(size),
        .unsigned_ld(unsigned_ld),
        .addr(addr),
        .wdata(wdata),
        .ready(ready),
        .valid(valid),
        .rdata(rdata),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    bit          err_q[$];
    int          edge_q[$];
    string       name_q[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    logic [31:0] m_exp;
    bit          m_err;
    int          m_edge;
    string       m_name;
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_valid: got valid with rdata %h, required no completion", rdata);
            end else begin
                m_exp  = exp_q.pop_front();
                m_err  = err_q.pop_front();
                m_edge = edge_q.pop_front();
                m_name = name_q.pop_front();
                check({m_name, " rdata"}, rdata, m_exp);
                check({m_name, " misalign_err"}, {31'd0, misalign_err}, {31'd0, m_err});
                // valid is sampled at edge k+1+W (k+1 for errors) after accept edge k
                check({m_name, " valid_edge"}, cyc + 1, m_edge);
            end
        end
    end

    task automatic send(input string nm, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit exp_err, input bit push,
                        output int acc);
        int n;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_total++;
            $display("FAIL %s accept: ready stayed 0 for %0d cycles, required 1", nm, n);
            req = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (push) begin
                exp_q.push_back(exp_rd);
                err_q.push_back(exp_err);
                edge_q.push_back(acc + 1 + (exp_err ? 0 : W));
                name_q.push_back(nm);
            end
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input string nm, input bit w, input logic [1:0] sz, input bit u,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit exp_err);
        int acc;
        send(nm, w, sz, u, a, d, exp_rd, exp_err, 1'b1, acc);
        idle(W + 3);
    endtask

    int a0, a1, a2, a3, ab;

    initial begin
        repeat (3) begin
            @(negedge clk);
            check("reset ready", {31'd0, ready}, 32'd0);
            check("reset valid", {31'd0, valid}, 32'd0);
            check("reset rdata", rdata, 32'd0);
        end
        check("reset misalign_err", {31'd0, misalign_err}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", {31'd0, ready}, 32'd1);

        //  name         we  size  uns  addr        wdata         exp rdata     err
        go("st_w_40",    1, 2'd2, 0, 32'h40,   32'hDEADBEEF, 32'h00000000, 0);
        go("ld_w_40",    0, 2'd2, 0, 32'h40,   32'h0,        32'hDEADBEEF, 0);
        go("ld_b_43",    0, 2'd0, 0, 32'h43,   32'h0,        32'hFFFFFFDE, 0);
        go("ld_bu_41",   0, 2'd0, 1, 32'h41,   32'h0,        32'h000000BE, 0);
        go("ld_h_42",    0, 2'd1, 0, 32'h42,   32'h0,        32'hFFFFDEAD, 0);
        go("st_b_41",    1, 2'd0, 0, 32'h41,   32'hAAAAAA11, 32'hFFFFDEAD, 0);
        go("ld_w_40b",   0, 2'd2, 0, 32'h40,   32'h0,        32'hDEAD11EF, 0);
        go("ld_hu_40",   0, 2'd1, 1, 32'h40,   32'h0,        32'h000011EF, 0);
        go("st_w_44",    1, 2'd2, 0, 32'h44,   32'hCAFEF00D, 32'h000011EF, 0);
        go("ld_h_41",    0, 2'd1, 0, 32'h41,   32'h0,        32'h000011EF, 1);
        go("st_w_42",    1, 2'd2, 0, 32'h42,   32'h12345678, 32'h000011EF, 1);
        go("ld_d_48",    0, 2'd3, 0, 32'h48,   32'h0,        32'h000011EF, 1);
        go("ld_wu_40",   0, 2'd2, 1, 32'h40,   32'h0,        32'hDEAD11EF, 0);
        go("ld_w_44",    0, 2'd2, 0, 32'h44,   32'h0,        32'hCAFEF00D, 0);
        go("ld_w_8040",  0, 2'd2, 0, 32'h8040, 32'h0,        32'hDEAD11EF, 0);
        go("ld_b_40",    0, 2'd0, 0, 32'h40,   32'h0,        32'hFFFFFFEF, 0);

        // req held high across four requests; accepts land in the DONE cycles
        send("bb_st_w_50", 1, 2'd2, 0, 32'h50, 32'h01020304, 32'hFFFFFFEF, 0, 1, a0);
        send("bb_ld_w_50", 0, 2'd2, 0, 32'h50, 32'h0,        32'h01020304, 0, 1, a1);
        send("bb_st_b_53", 1, 2'd0, 0, 32'h53, 32'h00000099, 32'h01020304, 0, 1, a2);
        send("bb_ld_w_50", 0, 2'd2, 0, 32'h50, 32'h0,        32'h99020304, 0, 1, a3);
        idle(W + 3);
        check("bb spacing 0-1", a1 - a0, W + 1);
        check("bb spacing 1-2", a2 - a1, W + 1);
        check("bb spacing 2-3", a3 - a2, W + 1);

        go("st_w_80",    1, 2'd2, 0, 32'h80,   32'h55667788, 32'h99020304, 0);
        send("st_w_80_abort", 1, 2'd2, 0, 32'h80, 32'hAABBCCDD, 32'h0, 0, 0, ab);
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midreset ready", {31'd0, ready}, 32'd0);
            check("midreset valid", {31'd0, valid}, 32'd0);
            check("midreset rdata", rdata, 32'd0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready after midreset", {31'd0, ready}, 32'd1);
        go("ld_w_80",    0, 2'd2, 0, 32'h80,   32'h0,        32'h55667788, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
